demux14_reg: RTL and testbench
==============================

Name: demux14_reg

Overview:
- Registered 1-to-4 demultiplexer with a valid/ready handshake; the distributing counterpart of the team's 4-to-1 select mux.
- Routes one WIDTH-bit input word to one of four output channels chosen by the 2-bit select S.
- Each channel has a one-entry holding register, so a stalled destination blocks only its own channel.
- Used ahead of per-destination logic (e.g. register-file write ports or functional units) fed from a single source.

Parameters:
WIDTH, 5, data width of D and Y0..Y3

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
D  input  WIDTH  input data word
S  input  2  destination select: 0->Y0, 1->Y1, 2->Y2, 3->Y3
VALID  input  1  D/S valid this cycle
READY  output  1  block can accept D this cycle (combinational)
Y0..Y3  output  WIDTH each  channel data, registered
V0..V3  output  1 each  channel holds valid data, registered
R0..R3  input  1 each  downstream ready for channel i
COUNT  output  8  total accepted input transfers, registered

Behaviour:
- Reset (rst_n=0 at rising edge): V0..V3=0, Y0..Y3=0, COUNT=0. The reset takes priority over every other event that cycle. Pending channel data is discarded with no drain.
- READY is combinational: READY = !V[S] | R[S]. It depends only on S, the selected channel's V, and the selected channel's R. It does not depend on VALID.
- accept = VALID & READY.
- On accept:
  - Y[S] <= D and V[S] <= 1 at the next edge.
  - Latency from input to Y/V is 1 cycle.
  - COUNT <= COUNT+1, wrapping 255->0.
- Drain: when Vi & Ri, the word is consumed and Vi <= 0 at the next edge, unless the same channel is reloaded that cycle.
- Simultaneous drain and reload on the same channel (V[S]=1, R[S]=1, VALID=1): Y[S] <= D and V[S] stays 1. This gives full throughput of one word per cycle per channel.
- Non-selected channels are unaffected by the input. They drain independently in the same cycle.
- Yi holds its last value when Vi=0. Yi changes only on accept to channel i or on reset.
- Stall (VALID=1, V[S]=1, R[S]=0):
  - READY=0, no state change on channel S, COUNT unchanged.
  - The source holds D/S stable until accepted.
  - The source may change S to a free channel while stalled; READY re-evaluates for the new S.
- VALID=0: no accept. D and S are ignored, except that READY still reflects S.
- Ri asserted while Vi=0 has no effect.
- Once Vi=1, Yi and Vi remain stable until Vi & Ri.
- Implementation: per-channel state is a two-state FSM, EMPTY <-> FULL.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on hold, or on drain+load.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, all R=1 -> V0..V3=0, Y0..Y3=0, COUNT=0, READY=1 for every S.
- Basic routing: D=5'b10101, S=2, VALID=1 for one cycle, R2=0 -> next cycle V2=1, Y2=10101, V0/V1/V3=0, COUNT=1; with S=2 held, READY=0 while R2=0.
- Stall then release: with channel 2 full and R2=0, present D=5'b00011, S=2, VALID=1 -> READY=0, Y2 stays 10101, COUNT=1; raise R2 -> same cycle READY=1, next edge Y2=00011, V2=1, COUNT=2.
- Back-to-back throughput: R0=1, send D=1,2,3,4 on consecutive cycles with S=0 -> Y0 shows 1,2,3,4 on consecutive cycles, V0 held 1, COUNT increments by 1 each cycle.
- Independent channels: fill channel 1 with R1=0, then send D=5'b11111 to S=3 with R3=1 -> accepted immediately (READY=1), Y3=11111, while Y1/V1 are unchanged.
- Counter wrap and reset mid-operation: 256 accepts -> COUNT=0; with V0=1, V2=1, assert rst_n=0 together with VALID=1 -> next edge all V=0, Y=0, COUNT=0, input not captured.

Source files
------------

// File: rtl/demux14_reg_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer: input handshake,
// the four output channels with their per-channel ready lines, and the transfer count.
interface demux14_reg_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] D;
  logic [1:0]       S;
  logic             VALID;
  logic             READY;
  logic [WIDTH-1:0] Y0, Y1, Y2, Y3;
  logic             V0, V1, V2, V3;
  logic             R0, R1, R2, R3;
  logic [7:0]       COUNT;

  modport master (
    output D, S, VALID, R0, R1, R2, R3,
    input  READY, Y0, Y1, Y2, Y3, V0, V1, V2, V3, COUNT
  );

  modport slave (
    input  D, S, VALID, R0, R1, R2, R3,
    output READY, Y0, Y1, Y2, Y3, V0, V1, V2, V3, COUNT
  );
endinterface

// File: rtl/demux14_reg.sv
// Registered 1-to-4 demultiplexer. Each channel has a one-entry holding register, so a
// stalled destination blocks only its own channel. A 256-wrapping counter tracks accepts.
module demux14_reg #(
  parameter int WIDTH = 5
) (
  input logic          clk,
  input logic          rst_n,
  demux14_reg_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chanState_t;

  chanState_t       chanState_r [4];
  logic [WIDTH-1:0] chanData_r  [4];
  logic [7:0]       count_r;

  logic [3:0] drainReady_s;
  logic       ready_s;
  logic       accept_s;

  // Input-side handshake: ready whenever the selected slot is empty or draining this cycle
  always_comb begin
    drainReady_s = {bus.R3, bus.R2, bus.R1, bus.R0};
    ready_s      = 1'b0;
    if (chanState_r[bus.S] == EMPTY) begin
      ready_s = 1'b1;
    end else begin
      ready_s = drainReady_s[bus.S];
    end
    accept_s = bus.VALID & ready_s;
  end

  // Per-channel EMPTY/FULL state, holding data and the accept counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chanState_r[i] <= EMPTY;
        chanData_r[i]  <= '0;
      end
      count_r <= 8'd0;
    end else begin
      if (accept_s) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
      for (int i = 0; i < 4; i++) begin
        // A load always wins over a drain; that is what gives one word per cycle per channel
        if (accept_s && (bus.S == 2'(i))) begin
          chanState_r[i] <= FULL;
          chanData_r[i]  <= bus.D;
        end else begin
          case (chanState_r[i])
            FULL: begin
              if (drainReady_s[i]) begin
                chanState_r[i] <= EMPTY;
              end else begin
                chanState_r[i] <= FULL;
              end
            end
            EMPTY:   chanState_r[i] <= EMPTY;
            default: chanState_r[i] <= EMPTY;
          endcase
        end
      end
    end
  end

  assign bus.READY = ready_s;
  assign bus.COUNT = count_r;
  assign bus.Y0    = chanData_r[0];
  assign bus.Y1    = chanData_r[1];
  assign bus.Y2    = chanData_r[2];
  assign bus.Y3    = chanData_r[3];
  assign bus.V0    = (chanState_r[0] == FULL);
  assign bus.V1    = (chanState_r[1] == FULL);
  assign bus.V2    = (chanState_r[2] == FULL);
  assign bus.V3    = (chanState_r[3] == FULL);

endmodule

// File: tb/tb_demux14_reg.sv
// Directed bench for demux14_reg: reset, routing, stall/release, throughput,
// channel independence, counter wrap and reset while busy.
module tb_demux14_reg;

  logic clk;
  logic rst_n;
  int   passCnt;
  int   totalCnt;

  demux14_reg_if #(.WIDTH(5)) bus ();

  demux14_reg #(.WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReady(input logic [3:0] r);
    bus.R0 = r[0];
    bus.R1 = r[1];
    bus.R2 = r[2];
    bus.R3 = r[3];
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    rst_n     = 1'b0;
    bus.D     = 5'd0;
    bus.S     = 2'd0;
    bus.VALID = 1'b0;
    setReady(4'b1111);

    // Reset then idle
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_v", {bus.V3, bus.V2, bus.V1, bus.V0}, 4'b0000);
    chk("rst_y0", bus.Y0, 5'd0);
    chk("rst_y1", bus.Y1, 5'd0);
    chk("rst_y2", bus.Y2, 5'd0);
    chk("rst_y3", bus.Y3, 5'd0);
    chk("rst_count", bus.COUNT, 8'd0);
    for (int s = 0; s < 4; s++) begin
      bus.S = 2'(s);
      #1;
      chk("rst_ready", bus.READY, 1'b1);
    end

    // Basic routing to channel 2, held by R2=0
    setReady(4'b1011);
    bus.D     = 5'b10101;
    bus.S     = 2'd2;
    bus.VALID = 1'b1;
    tick();
    bus.VALID = 1'b0;
    chk("route_v", {bus.V3, bus.V2, bus.V1, bus.V0}, 4'b0100);
    chk("route_y2", bus.Y2, 5'b10101);
    chk("route_count", bus.COUNT, 8'd1);
    #1;
    chk("route_ready", bus.READY, 1'b0);

    // Stall, then release in the same cycle as reload
    bus.D     = 5'b00011;
    bus.VALID = 1'b1;
    #1;
    chk("stall_ready", bus.READY, 1'b0);
    tick();
    chk("stall_y2", bus.Y2, 5'b10101);
    chk("stall_v2", bus.V2, 1'b1);
    chk("stall_count", bus.COUNT, 8'd1);
    bus.S = 2'd0;
    #1;
    chk("stall_resel_ready", bus.READY, 1'b1);
    bus.S = 2'd2;
    bus.R2 = 1'b1;
    #1;
    chk("release_ready", bus.READY, 1'b1);
    tick();
    bus.VALID = 1'b0;
    chk("release_y2", bus.Y2, 5'b00011);
    chk("release_v2", bus.V2, 1'b1);
    chk("release_count", bus.COUNT, 8'd2);

    // Back-to-back on channel 0
    for (int d = 1; d <= 4; d++) begin
      bus.D     = 5'(d);
      bus.S     = 2'd0;
      bus.VALID = 1'b1;
      tick();
      chk("b2b_y0", bus.Y0, 5'(d));
      chk("b2b_v0", bus.V0, 1'b1);
      chk("b2b_count", bus.COUNT, 8'(2 + d));
    end
    bus.VALID = 1'b0;
    tick();
    chk("drain_v", {bus.V3, bus.V2, bus.V1, bus.V0}, 4'b0000);

    // Independent channels: 1 stalled, 3 free
    setReady(4'b1101);
    bus.D     = 5'd7;
    bus.S     = 2'd1;
    bus.VALID = 1'b1;
    tick();
    chk("ind_v1", bus.V1, 1'b1);
    chk("ind_y1", bus.Y1, 5'd7);
    bus.D = 5'b11111;
    bus.S = 2'd3;
    #1;
    chk("ind_ready3", bus.READY, 1'b1);
    tick();
    bus.VALID = 1'b0;
    chk("ind_y3", bus.Y3, 5'b11111);
    chk("ind_v3", bus.V3, 1'b1);
    chk("ind_y1_hold", bus.Y1, 5'd7);
    chk("ind_v1_hold", bus.V1, 1'b1);
    chk("ind_count", bus.COUNT, 8'd8);

    // Counter wrap via channel 0 (8 + 248 = 256)
    bus.S     = 2'd0;
    bus.VALID = 1'b1;
    for (int i = 0; i < 248; i++) begin
      bus.D = 5'(i);
      tick();
      if (i == 246) chk("wrap_255", bus.COUNT, 8'd255);
    end
    chk("wrap_0", bus.COUNT, 8'd0);

    // Fill 0 and 2, then reset with VALID high
    setReady(4'b1000);
    bus.D = 5'd9;
    bus.S = 2'd2;
    tick();
    chk("pre_rst_v", {bus.V2, bus.V0}, 2'b11);
    chk("pre_rst_count", bus.COUNT, 8'd1);
    rst_n = 1'b0;
    bus.D = 5'd13;
    bus.S = 2'd3;
    tick();
    rst_n     = 1'b1;
    bus.VALID = 1'b0;
    chk("midrst_v", {bus.V3, bus.V2, bus.V1, bus.V0}, 4'b0000);
    chk("midrst_y", {bus.Y3, bus.Y2, bus.Y1, bus.Y0}, 20'd0);
    chk("midrst_count", bus.COUNT, 8'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
